shift_add_mul_seq: RTL

Sequential unsigned multiplier controller that time-shares a single W-bit ripple adder to compute a full 2W-bit product by radix-2 shift-and-add. It accepts one operand pair per transaction over a valid/ready handshake, runs a fixed-latency iteration FSM around the adder, and returns the product over a second valid/ready handshake. It is the area-minimal serial baseline that the multiplier variants are compared against.

---
 rtl/mul_seq_pkg.sv | 12 +
 rtl/shift_add_mul_seq_adder.sv | 24 ++
 rtl/shift_add_mul_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the serial shift-and-add multiplier.
// The width default and counter width live here so that every file sees the same sizes.
package mul_seq_pkg;
   localparam int W     = 11;
   localparam int CNT_W = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/shift_add_mul_seq_adder.sv
// W-bit ripple-carry adder; purely combinational, so no latency or backpressure.
// This adder is the only arithmetic in the multiplier datapath.
module shift_add_mul_seq_adder #(
   parameter int W = 11
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   logic w_carry;

   // A scalar carry walked bit by bit keeps the chain free of self-referencing vectors.
   always_comb begin
      w_carry = cin;
      s       = '0;
      for (int i = 0; i < W; i++) begin
         s[i]    = a[i] ^ b[i] ^ w_carry;
         w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
      end
      cout = w_carry;
   end
endmodule

// File: rtl/shift_add_mul_seq.sv
// Serial radix-2 shift-and-add unsigned multiplier; W cycles from acceptance to out_valid.
// in_ready is low from acceptance until the product is taken; out_valid/product hold under backpressure.
module shift_add_mul_seq
   import mul_seq_pkg::*;
#(
   parameter int W = mul_seq_pkg::W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a_in,
   input  logic [W-1:0]   b_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] product,
   output logic           busy
);
   localparam int CW = $clog2(W);

   state_t           r_state;
   logic [W-1:0]     r_m;
   logic [W-1:0]     r_q;
   logic [W-1:0]     r_acc;
   logic [CW-1:0]    r_cnt;
   logic [2*W-1:0]   r_product;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [W-1:0]     w_addend;
   logic [W-1:0]     w_sum;
   logic             w_cout;
   logic [2*W-1:0]   w_next;

   assign w_addend = r_q[0] ? r_m : '0;
   // The (W+1)-bit sum lands on top of Q shifted right by one; the carry becomes ACC's MSB.
   assign w_next   = {w_cout, w_sum, r_q[W-1:1]};

   shift_add_mul_seq_adder #(.W(W)) u_adder (
      .a    (r_acc),
      .b    (w_addend),
      .cin  (1'b0),
      .s    (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_m         <= '0;
         r_q         <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_product   <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_m        <= a_in;
                  r_q        <= b_in;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= CALC;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            CALC: begin
               {r_acc, r_q} <= w_next;
               r_cnt        <= r_cnt + CW'(1);
               if (r_cnt == CW'(W - 1)) begin
                  r_state     <= DONE;
                  r_product   <= w_next;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign product   = r_product;
   assign busy      = r_busy;
endmodule
